// File: rtl/tag_collect_pkg.sv
// Shared constants and the round-robin pick helper for the tag collector.
// Pure combinational helpers; no state, no latency, no flow control.
// Callers apply their own space/backpressure gating around rr_pick.
package tag_collect_pkg;

    localparam int NCOUNT_DEF = 8;
    localparam int DW_DEF     = 10;
    localparam int RR_MAX     = 32;
    localparam int RR_IW      = 5;

    typedef struct packed {
        logic             found;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or above ptr, wrapping modulo n (n <= RR_MAX, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [RR_IW-1:0]  ptr,
                                         input int                n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.found && req[j]) begin
                    res.found = 1'b1;
                    res.idx   = RR_IW'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tag_sync_fifo.sv
// Shift-register FIFO whose entry 0 is the registered show-ahead head.
// Latency: a push is visible at the head one edge later when empty.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module tag_sync_fifo #(
    parameter  int DW    = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] wr_idx;
    logic          pop_eff, push_eff;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign level    = level_q;
    assign head_dat = mem_q[0];

    always_comb begin
        pop_eff  = pop & ~empty;
        push_eff = push & (~full | pop_eff);
        // DEPTH is a power of two, so the wrap from a full level lands on the last slot.
        wr_idx   = level_q[AW-1:0] - AW'(pop_eff);
        mem_d    = mem_q;
        if (pop_eff) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        if (push_eff) begin
            mem_d[wr_idx] = push_dat;
        end
        level_d = level_q + LW'(push_eff) - LW'(pop_eff);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/tag_rr_collector.sv
// Round-robin merge of per-node match tags into one ready/valid tag stream.
// Latency: a tag acked at edge t is at the output after t when the FIFO is empty.
// Backpressure: no ack is issued unless the FIFO has a slot or pops this cycle.
module tag_rr_collector
    import tag_collect_pkg::*;
#(
    parameter  int NCOUNT = NCOUNT_DEF,
    parameter  int DW     = DW_DEF,
    parameter  int DEPTH  = 4,
    localparam int LW     = $clog2(DEPTH) + 1,
    localparam int PW     = (NCOUNT > 1) ? $clog2(NCOUNT) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NCOUNT*DW-1:0] node_data,
    input  logic [NCOUNT-1:0]    node_valid,
    output logic [NCOUNT-1:0]    node_ack,
    input  logic [NCOUNT-1:0]    node_enable,
    input  logic [NCOUNT-1:0]    node_freeze,
    input  logic                 global_freeze,
    output logic [DW-1:0]        tag_data,
    output logic                 tag_valid,
    input  logic                 tag_ready,
    output logic [31:0]          tag_count,
    output logic [LW-1:0]        fifo_level
);

    logic [NCOUNT-1:0] elig;
    logic              pop, space, grant_vld;
    logic              fifo_full, fifo_empty;
    logic [DW-1:0]     grant_dat;
    rr_pick_t          pick;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [31:0]       tag_count_q, tag_count_d;

    always_comb begin
        elig      = node_valid & node_enable & ~node_freeze & {NCOUNT{~global_freeze}};
        pop       = tag_valid & tag_ready;
        space     = ~fifo_full | pop;
        pick      = rr_pick(RR_MAX'(elig), RR_IW'(ptr_q), NCOUNT);
        grant_vld = space & pick.found;
        grant_dat = node_data[int'(pick.idx)*DW +: DW];

        // Gated by reset_n so a held reset never shows an ack to the nodes.
        node_ack = '0;
        if (grant_vld && reset_n) begin
            node_ack = NCOUNT'(1) << pick.idx;
        end

        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (int'(pick.idx) == NCOUNT - 1) ? '0 : PW'(int'(pick.idx) + 1);
        end

        tag_count_d = tag_count_q + 32'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            tag_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_count_q <= tag_count_d;
        end
    end

    tag_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (grant_vld),
        .push_dat (grant_dat),
        .pop      (pop),
        .head_dat (tag_data),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tag_valid = ~fifo_empty;
    assign tag_count = tag_count_q;

endmodule
